extensor_imediato_pipe: RTL and testbench

- Pipelined immediate generator for the MIPS datapath.
- Takes the raw 26-bit instruction field and a mode code. Produces a LARGURA-bit extended, shifted or placed immediate.
- Result is delivered through a 2-entry output buffer with valid/ready handshake, so decode can stall without losing results.
- Successor to the combinational 16/26-bit sign extender: adds zero-extend, LUI, branch and jump modes, parametrised width, registered output and backpressure.

---
 rtl/extensor_imediato_pipe.sv | 118 +++++++++++
 tb/tb_extensor_imediato_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/extensor_imediato_pipe.sv
// ---------------------------------------------------------------------------
// extensor_imediato_pipe
// Pipelined immediate generator for the MIPS datapath. The raw 26-bit
// instruction field is extended / shifted / placed according to modo. The
// result is then queued in a small output buffer with a valid/ready
// handshake, so decode can stall without losing results.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   entrada_valid  campo/modo valid this cycle
//   entrada_ready  buffer has a free slot (registered count only)
//   campo [25:0]   instruction bits [25:0]
//   modo  [2:0]    000 SEXT16, 001 ZEXT16, 010 LUI, 011 SEXT26,
//                  100 BR, 101 JMP, 110/111 illegal
//   saida_valid    saida/erro hold a valid result
//   saida_ready    consumer takes the result this cycle
//   saida [LARGURA-1:0]  extended immediate (head-entry register)
//   erro           result came from an illegal modo
// ---------------------------------------------------------------------------
module extensor_imediato_pipe #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               entrada_valid,
  output logic               entrada_ready,
  input  logic [25:0]        campo,
  input  logic [2:0]         modo,
  output logic               saida_valid,
  input  logic               saida_ready,
  output logic [LARGURA-1:0] saida,
  output logic               erro
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = $clog2(PROFUNDIDADE) + 1;

  typedef enum logic [2:0] {
    M_SEXT16 = 3'b000,
    M_ZEXT16 = 3'b001,
    M_LUI    = 3'b010,
    M_SEXT26 = 3'b011,
    M_BR     = 3'b100,
    M_JMP    = 3'b101
  } modo_t;

  logic [LARGURA-1:0] amplo;
  logic               erro_calc;
  logic [LARGURA:0]   entrada_ent;

  // Size casts of signed operands sign-extend up to LARGURA-1.
  always_comb begin
    amplo     = '0;
    erro_calc = 1'b0;
    case (modo_t'(modo))
      M_SEXT16: amplo = LARGURA'($signed(campo[15:0]));
      M_ZEXT16: amplo = LARGURA'(campo[15:0]);
      M_LUI:    amplo = LARGURA'($signed({campo[15:0], 16'h0000}));
      M_SEXT26: amplo = LARGURA'($signed(campo));
      M_BR:     amplo = LARGURA'($signed({campo[15:0], 2'b00}));
      M_JMP:    amplo = LARGURA'({campo, 2'b00});
      default:  erro_calc = 1'b1;
    endcase
  end

  assign entrada_ent = {erro_calc, amplo};

  logic [LARGURA:0] mem [PROFUNDIDADE];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]    count, count_rest, count_next;
  logic [LARGURA:0] cabeca;
  logic             push, pop;

  assign entrada_ready = (count < CW'(PROFUNDIDADE));
  assign saida_valid   = (count != '0);
  assign push          = entrada_valid && entrada_ready;
  assign pop           = saida_valid && saida_ready;

  // Pointers wrap naturally because PROFUNDIDADE is a power of two.
  assign rd_next    = rd_ptr + PW'(pop);
  assign count_rest = count - CW'(pop);
  assign count_next = count_rest + CW'(push);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entrada_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      count  <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // The head register is preloaded with whatever will be at the front after
  // this edge: the incoming word when no older entry survives, otherwise the
  // stored entry at the new read pointer. When the buffer drains it simply
  // holds, so saida keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cabeca <= '0;
    end else if (count_next != '0) begin
      if (push && (count_rest == '0)) cabeca <= entrada_ent;
      else                            cabeca <= mem[rd_next];
    end
  end

  assign saida = cabeca[LARGURA-1:0];
  assign erro  = cabeca[LARGURA];

endmodule

// File: tb/tb_extensor_imediato_pipe.sv
module tb_extensor_imediato_pipe;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entrada_valid = 1'b0;
  logic        saida_ready = 1'b0;
  logic [25:0] campo = '0;
  logic [2:0]  modo = '0;

  logic        rdy32, val32, erro32;
  logic [31:0] s32;
  logic        rdy64, val64, erro64;
  logic [63:0] s64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  extensor_imediato_pipe #(.LARGURA(32), .PROFUNDIDADE(P)) dut32 (
    .clk(clk), .rst_n(rst_n), .entrada_valid(entrada_valid), .entrada_ready(rdy32),
    .campo(campo), .modo(modo), .saida_valid(val32), .saida_ready(saida_ready),
    .saida(s32), .erro(erro32)
  );

  extensor_imediato_pipe #(.LARGURA(64), .PROFUNDIDADE(P)) dut64 (
    .clk(clk), .rst_n(rst_n), .entrada_valid(entrada_valid), .entrada_ready(rdy64),
    .campo(campo), .modo(modo), .saida_valid(val64), .saida_ready(saida_ready),
    .saida(s64), .erro(erro64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: 64-bit result computed with signed integer arithmetic;
  // the 32-bit instance is the low half. Bit 64 is erro.
  function automatic logic [64:0] ref_calc(input logic [25:0] c, input logic [2:0] m);
    longint r;
    logic   e;
    e = 1'b0;
    case (m)
      3'd0: r = longint'(shortint'(c[15:0]));
      3'd1: r = longint'(c[15:0]);
      3'd2: r = longint'(int'({c[15:0], 16'h0000}));
      3'd3: r = (longint'(c) <<< 38) >>> 38;
      3'd4: r = longint'(shortint'(c[15:0])) * 4;
      3'd5: r = longint'(c) * 4;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Behavioural queue model and per-cycle comparison.
  logic [64:0] q[$];
  logic [64:0] last = '0;
  bit          mpush, mpop;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        last = '0;
      end else begin
        mpush = entrada_valid && (q.size() < P);
        mpop  = (q.size() > 0) && saida_ready;
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(ref_calc(campo, modo));
        if (q.size() > 0) last = q[0];
      end
      #1;
      if (rst_n) begin
        chk("valid32", 64'(val32), 64'(q.size() > 0));
        chk("ready32", 64'(rdy32), 64'(q.size() < P));
        chk("saida32", 64'(s32),   64'(last[31:0]));
        chk("erro32",  64'(erro32), 64'(last[64]));
        chk("valid64", 64'(val64), 64'(q.size() > 0));
        chk("ready64", 64'(rdy64), 64'(q.size() < P));
        chk("saida64", s64,        last[63:0]);
        chk("erro64",  64'(erro64), 64'(last[64]));
      end
    end
  end

  // Producer: holds data until accepted (ready sampled between edges).
  task automatic send(input logic [25:0] c, input logic [2:0] m);
    int n;
    entrada_valid = 1'b1;
    campo = c;
    modo  = m;
    n = 0;
    while (!rdy32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    @(negedge clk);
    entrada_valid = 1'b0;
  endtask

  initial begin
    // Model pins against hand-computed values.
    chk("ref_sext16", 64'(ref_calc(26'h0008000, 3'd0) & 65'hFFFFFFFF), 64'hFFFF8000);
    chk("ref_zext16", 64'(ref_calc(26'h0008000, 3'd1) & 65'hFFFFFFFF), 64'h00008000);
    chk("ref_lui",    64'(ref_calc(26'h0001234, 3'd2) & 65'hFFFFFFFF), 64'h12340000);
    chk("ref_sext26", 64'(ref_calc(26'h2000000, 3'd3) & 65'hFFFFFFFF), 64'hFE000000);
    chk("ref_br",     64'(ref_calc(26'h000FFFF, 3'd4) & 65'hFFFFFFFF), 64'hFFFFFFFC);
    chk("ref_jmp",    64'(ref_calc(26'h3FFFFFF, 3'd5) & 65'hFFFFFFFF), 64'h0FFFFFFC);
    chk("ref_ill",    64'(ref_calc(26'h3FFFFFF, 3'd6) >> 64), 64'h1);
    chk("ref_lui64",  ref_calc(26'h0008000, 3'd2) & 65'h0FFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000);
    chk("ref_sext64", ref_calc(26'h0007FFF, 3'd0) & 65'h0FFFFFFFFFFFFFFFF, 64'h0000000000007FFF);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(val32), 64'h0);
    chk("rst_saida", 64'(s32), 64'h0);
    chk("rst_erro",  64'(erro32), 64'h0);
    chk("rst_ready", 64'(rdy32), 64'h1);

    // Directed mode sweep, continuous acceptance.
    saida_ready = 1'b1;
    send(26'h0008000, 3'd0);
    send(26'h0008000, 3'd1);
    send(26'h0001234, 3'd2);
    send(26'h2000000, 3'd3);
    send(26'h000FFFF, 3'd4);
    send(26'h3FFFFFF, 3'd5);
    send(26'h3FFFFFF, 3'd6);
    send(26'h0007FFF, 3'd1);
    send(26'h0008000, 3'd2);
    send(26'h0007FFF, 3'd0);
    repeat (2) @(negedge clk);

    // Backpressure: A, B fill the buffer, C waits for A to pop.
    saida_ready = 1'b0;
    fork
      begin
        send(26'h0000111, 3'd0);
        send(26'h0000222, 3'd1);
        send(26'h0000333, 3'd3);
      end
      begin
        repeat (5) @(negedge clk);
        saida_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    // Steady push/pop at count=1, pointers wrapping.
    for (int i = 0; i < 20; i++) send(26'($urandom), 3'($urandom_range(0, 5)));
    repeat (2) @(negedge clk);

    // Random traffic including illegal modes and ignored pushes.
    for (int i = 0; i < 400; i++) begin
      entrada_valid = 1'($urandom_range(0, 1));
      campo = 26'($urandom);
      modo  = 3'($urandom_range(0, 7));
      saida_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    entrada_valid = 1'b0;
    saida_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset with two buffered entries.
    saida_ready = 1'b0;
    send(26'h0000ABC, 3'd0);
    send(26'h0000DEF, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid32", 64'(val32), 64'h0);
    chk("arst_saida32", 64'(s32), 64'h0);
    chk("arst_valid64", 64'(val64), 64'h0);
    chk("arst_saida64", s64, 64'h0);
    chk("arst_erro32",  64'(erro32), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 64'(rdy32), 64'h1);
    saida_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_nostale", 64'(val32), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
